// File: rtl/i2s_frame_fifo.sv
// i2s_frame_fifo
// Pairs left/right channel samples from the I2S receiver into stereo frames.
// Frames are buffered in a first-word-fall-through FIFO that the host drains
// over a valid/ready handshake. Everything runs on SCK; there is no CDC here.
//
// Optional build macro: I2S_FRAME_FIFO_OVF_CNT_EN adds a saturating
// dropped-frame counter on o_ovf_cnt. Without it the port and counter are absent.
//
// Ports:
//   clk, rst                      SCK, asynchronous active-high reset
//   i_left_data/i_left_vld        left sample and its one-cycle strobe
//   i_right_data/i_right_vld      right sample and its one-cycle strobe
//   o_frame_left/o_frame_right    head frame (zero while empty)
//   o_frame_vld/i_frame_rdy       read handshake; pop on vld & rdy
//   o_count, o_full               occupancy (0..2**DEPTH_LOG2) and full flag
//   o_ovf, o_desync, i_flag_clr   sticky error flags and their clear
//   o_ovf_cnt                     dropped-frame count (optional)
//
// Pair FSM states:
//   WAIT_L | no left sample pending; waiting for a left strobe
//   HAVE_L | a left sample is held; waiting for its right partner

module i2s_frame_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_LOG2    = 4,
    parameter int OVF_CNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_left_data,
    input  logic                  i_left_vld,
    input  logic [DATA_WIDTH-1:0] i_right_data,
    input  logic                  i_right_vld,
    output logic [DATA_WIDTH-1:0] o_frame_left,
    output logic [DATA_WIDTH-1:0] o_frame_right,
    output logic                  o_frame_vld,
    input  logic                  i_frame_rdy,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_ovf,
    output logic                  o_desync,
    input  logic                  i_flag_clr
`ifdef I2S_FRAME_FIFO_OVF_CNT_EN
    ,
    output logic [OVF_CNT_WIDTH-1:0] o_ovf_cnt
`endif
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    typedef enum logic {
        WAIT_L = 1'b0,
        HAVE_L = 1'b1
    } pair_state_t;

    pair_state_t state, state_next;

    logic [DATA_WIDTH-1:0]   held_left;
    logic                    latch_en;
    logic                    push;
    logic                    desync_evt;
    logic [DATA_WIDTH-1:0]   frame_left;
    logic [DATA_WIDTH-1:0]   frame_right;

    logic [2*DATA_WIDTH-1:0] mem [DEPTH];
    logic [2*DATA_WIDTH-1:0] head;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     count;
    logic                    frame_vld;
    logic                    full;
    logic                    pop;
    logic                    wr_en;
    logic                    drop;
    logic                    ovf;
    logic                    desync;

    // ------------------------------------------------------------------
    // Pair FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_L;
            held_left <= '0;
        end else begin
            state <= state_next;
            if (latch_en) begin
                held_left <= i_left_data;
            end
        end
    end

    always_comb begin
        state_next  = state;
        latch_en    = 1'b0;
        push        = 1'b0;
        desync_evt  = 1'b0;
        frame_left  = held_left;
        frame_right = i_right_data;
        unique case (state)
            WAIT_L: begin
                if (i_left_vld && i_right_vld) begin
                    // Both halves arrived together: bypass the holding register.
                    push       = 1'b1;
                    frame_left = i_left_data;
                end else if (i_left_vld) begin
                    latch_en   = 1'b1;
                    state_next = HAVE_L;
                end else if (i_right_vld) begin
                    desync_evt = 1'b1;
                end
            end
            HAVE_L: begin
                if (i_right_vld) begin
                    push = 1'b1;
                    if (i_left_vld) begin
                        // Completes the held frame and starts the next one.
                        latch_en = 1'b1;
                    end else begin
                        state_next = WAIT_L;
                    end
                end else if (i_left_vld) begin
                    latch_en   = 1'b1;
                    desync_evt = 1'b1;
                end
            end
            default: state_next = WAIT_L;
        endcase
    end

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    assign frame_vld = (count != '0);
    assign full      = (count == FULL_CNT);
    assign pop       = frame_vld && i_frame_rdy;
    // When full, a concurrent pop frees the slot the write lands in
    // (wr_ptr == rd_ptr), so the write is still accepted.
    assign wr_en     = push && (!full || pop);
    assign drop      = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {frame_left, frame_right};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign head          = mem[rd_ptr];
    assign o_frame_left  = frame_vld ? head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign o_frame_right = frame_vld ? head[DATA_WIDTH-1:0] : '0;
    assign o_frame_vld   = frame_vld;
    assign o_count       = count;
    assign o_full        = full;

    // ------------------------------------------------------------------
    // Sticky flags: a set event in the clearing cycle wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf    <= 1'b0;
            desync <= 1'b0;
        end else begin
            if (drop) begin
                ovf <= 1'b1;
            end else if (i_flag_clr) begin
                ovf <= 1'b0;
            end
            if (desync_evt) begin
                desync <= 1'b1;
            end else if (i_flag_clr) begin
                desync <= 1'b0;
            end
        end
    end

    assign o_ovf    = ovf;
    assign o_desync = desync;

`ifdef I2S_FRAME_FIFO_OVF_CNT_EN
    localparam logic [OVF_CNT_WIDTH-1:0] OVF_ONE = 1;
    localparam logic [OVF_CNT_WIDTH-1:0] OVF_MAX = '1;

    logic [OVF_CNT_WIDTH-1:0] ovf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (i_flag_clr) begin
            ovf_cnt <= drop ? OVF_ONE : '0;
        end else if (drop && (ovf_cnt != OVF_MAX)) begin
            ovf_cnt <= ovf_cnt + OVF_ONE;
        end
    end

    assign o_ovf_cnt = ovf_cnt;
`endif

endmodule

// File: tb/tb_i2s_frame_fifo.sv
// Directed bench for i2s_frame_fifo (default parameters). Inputs change and
// outputs are sampled 1 ns after the rising edge.

module tb_i2s_frame_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] left_data = '0;
    logic        left_vld = 1'b0;
    logic [31:0] right_data = '0;
    logic        right_vld = 1'b0;
    logic [31:0] frame_left;
    logic [31:0] frame_right;
    logic        frame_vld;
    logic        frame_rdy = 1'b0;
    logic [4:0]  count;
    logic        full;
    logic        ovf;
    logic        desync;
    logic        flag_clr = 1'b0;
`ifdef I2S_FRAME_FIFO_OVF_CNT_EN
    logic [7:0]  ovf_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    i2s_frame_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .i_left_data  (left_data),
        .i_left_vld   (left_vld),
        .i_right_data (right_data),
        .i_right_vld  (right_vld),
        .o_frame_left (frame_left),
        .o_frame_right(frame_right),
        .o_frame_vld  (frame_vld),
        .i_frame_rdy  (frame_rdy),
        .o_count      (count),
        .o_full       (full),
        .o_ovf        (ovf),
        .o_desync     (desync),
        .i_flag_clr   (flag_clr)
`ifdef I2S_FRAME_FIFO_OVF_CNT_EN
        ,
        .o_ovf_cnt    (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_left(input logic [31:0] d);
        left_data = d; left_vld = 1'b1;
        tick();
        left_vld = 1'b0;
    endtask

    task automatic send_right(input logic [31:0] d);
        right_data = d; right_vld = 1'b1;
        tick();
        right_vld = 1'b0;
    endtask

    task automatic send_both(input logic [31:0] l, input logic [31:0] r);
        left_data = l; left_vld = 1'b1;
        right_data = r; right_vld = 1'b1;
        tick();
        left_vld = 1'b0; right_vld = 1'b0;
    endtask

    task automatic clear_flags();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (frame_vld !== 1'b0) begin $display("FAIL reset_vld got %b want 0", frame_vld); n_bad++; end
        n_cmp++; if (count !== 5'd0) begin $display("FAIL reset_count got %0d want 0", count); n_bad++; end
        n_cmp++; if (full !== 1'b0 || ovf !== 1'b0 || desync !== 1'b0) begin
            $display("FAIL reset_flags got full=%b ovf=%b desync=%b want 000", full, ovf, desync); n_bad++; end
        n_cmp++; if (frame_left !== 32'h0 || frame_right !== 32'h0) begin
            $display("FAIL reset_data got %h/%h want 0/0", frame_left, frame_right); n_bad++; end
    endtask

    task automatic test_latency();
        send_left(32'h1111_1111);
        repeat (31) tick();
        n_cmp++; if (frame_vld !== 1'b0) begin $display("FAIL lat_pre_vld got %b want 0", frame_vld); n_bad++; end
        send_right(32'h2222_2222);
        n_cmp++; if (frame_vld !== 1'b1) begin $display("FAIL lat_vld got %b want 1", frame_vld); n_bad++; end
        n_cmp++; if (frame_left !== 32'h1111_1111 || frame_right !== 32'h2222_2222) begin
            $display("FAIL lat_data got %h/%h want 11111111/22222222", frame_left, frame_right); n_bad++; end
        n_cmp++; if (count !== 5'd1) begin $display("FAIL lat_count got %0d want 1", count); n_bad++; end
        frame_rdy = 1'b1; tick(); frame_rdy = 1'b0;
        n_cmp++; if (frame_vld !== 1'b0 || count !== 5'd0) begin
            $display("FAIL lat_pop got vld=%b count=%0d want 0/0", frame_vld, count); n_bad++; end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 16; i++) begin
            if (i % 2 == 1) begin
                send_left(32'hA000_0000 + i);
                send_right(32'hB000_0000 + i);
            end else begin
                send_both(32'hA000_0000 + i, 32'hB000_0000 + i);
            end
            n_cmp++; if (count !== 5'(i)) begin $display("FAIL ovf_fill_count got %0d want %0d", count, i); n_bad++; end
        end
        n_cmp++; if (full !== 1'b1 || ovf !== 1'b0) begin
            $display("FAIL ovf_full got full=%b ovf=%b want 1/0", full, ovf); n_bad++; end
        send_both(32'hA000_0011, 32'hB000_0011);
        n_cmp++; if (ovf !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
            $display("FAIL ovf_drop got ovf=%b count=%0d full=%b want 1/16/1", ovf, count, full); n_bad++; end
        n_cmp++; if (frame_left !== 32'hA000_0001 || frame_right !== 32'hB000_0001) begin
            $display("FAIL ovf_head_hold got %h/%h want a0000001/b0000001", frame_left, frame_right); n_bad++; end
        for (int i = 1; i <= 16; i++) begin
            n_cmp++; if (frame_vld !== 1'b1 || frame_left !== 32'hA000_0000 + i || frame_right !== 32'hB000_0000 + i) begin
                $display("FAIL ovf_drain got vld=%b %h/%h want frame %0d", frame_vld, frame_left, frame_right, i); n_bad++; end
            frame_rdy = 1'b1; tick(); frame_rdy = 1'b0;
        end
        n_cmp++; if (frame_vld !== 1'b0 || count !== 5'd0 || full !== 1'b0) begin
            $display("FAIL ovf_empty got vld=%b count=%0d full=%b want 0/0/0", frame_vld, count, full); n_bad++; end
        // Popping while empty must not move anything.
        frame_rdy = 1'b1; tick(); tick(); frame_rdy = 1'b0;
        n_cmp++; if (count !== 5'd0 || ovf !== 1'b1) begin
            $display("FAIL ovf_empty_rdy got count=%0d ovf=%b want 0/1", count, ovf); n_bad++; end
        clear_flags();
        n_cmp++; if (ovf !== 1'b0) begin $display("FAIL ovf_clr got %b want 0", ovf); n_bad++; end
    endtask

    task automatic test_full_pop();
        for (int i = 1; i <= 16; i++) send_both(32'hC000_0000 + i, 32'hD000_0000 + i);
        send_left(32'hC000_0011);
        right_data = 32'hD000_0011; right_vld = 1'b1; frame_rdy = 1'b1;
        tick();
        right_vld = 1'b0; frame_rdy = 1'b0;
        n_cmp++; if (ovf !== 1'b0 || count !== 5'd16 || full !== 1'b1) begin
            $display("FAIL fpop_state got ovf=%b count=%0d full=%b want 0/16/1", ovf, count, full); n_bad++; end
        for (int i = 2; i <= 17; i++) begin
            n_cmp++; if (frame_vld !== 1'b1 || frame_left !== 32'hC000_0000 + i || frame_right !== 32'hD000_0000 + i) begin
                $display("FAIL fpop_drain got vld=%b %h/%h want frame %0d", frame_vld, frame_left, frame_right, i); n_bad++; end
            frame_rdy = 1'b1; tick(); frame_rdy = 1'b0;
        end
        n_cmp++; if (frame_vld !== 1'b0) begin $display("FAIL fpop_empty got %b want 0", frame_vld); n_bad++; end
    endtask

    task automatic test_desync();
        send_right(32'h0000_0033);
        n_cmp++; if (desync !== 1'b1 || count !== 5'd0) begin
            $display("FAIL ds_orphan got desync=%b count=%0d want 1/0", desync, count); n_bad++; end
        clear_flags();
        n_cmp++; if (desync !== 1'b0) begin $display("FAIL ds_clr got %b want 0", desync); n_bad++; end
        send_left(32'h0000_00AA);
        send_left(32'h0000_00BB);
        n_cmp++; if (desync !== 1'b1) begin $display("FAIL ds_overwrite got %b want 1", desync); n_bad++; end
        send_right(32'h0000_00CC);
        n_cmp++; if (count !== 5'd1 || frame_left !== 32'h0000_00BB || frame_right !== 32'h0000_00CC) begin
            $display("FAIL ds_frame got count=%0d %h/%h want 1 bb/cc", count, frame_left, frame_right); n_bad++; end
        frame_rdy = 1'b1; tick(); frame_rdy = 1'b0;
        clear_flags();
    endtask

    task automatic test_back_to_back();
        send_both(32'hE000_0001, 32'hF000_0001);
        send_left(32'hE000_0002);
        send_both(32'hE000_0003, 32'hF000_0002);
        n_cmp++; if (count !== 5'd2) begin $display("FAIL b2b_count got %0d want 2", count); n_bad++; end
        right_data = 32'hF000_0003; right_vld = 1'b1; frame_rdy = 1'b1;
        tick();
        right_vld = 1'b0; frame_rdy = 1'b0;
        n_cmp++; if (count !== 5'd2 || desync !== 1'b0) begin
            $display("FAIL b2b_pushpop got count=%0d desync=%b want 2/0", count, desync); n_bad++; end
        n_cmp++; if (frame_left !== 32'hE000_0002 || frame_right !== 32'hF000_0002) begin
            $display("FAIL b2b_head1 got %h/%h want e0000002/f0000002", frame_left, frame_right); n_bad++; end
        frame_rdy = 1'b1; tick(); frame_rdy = 1'b0;
        n_cmp++; if (frame_left !== 32'hE000_0003 || frame_right !== 32'hF000_0003) begin
            $display("FAIL b2b_head2 got %h/%h want e0000003/f0000003", frame_left, frame_right); n_bad++; end
        frame_rdy = 1'b1; tick(); frame_rdy = 1'b0;
        n_cmp++; if (frame_vld !== 1'b0) begin $display("FAIL b2b_empty got %b want 0", frame_vld); n_bad++; end
    endtask

    task automatic test_flag_priority();
        for (int i = 0; i < 16; i++) send_both(32'h1000_0000 + i, 32'h2000_0000 + i);
        flag_clr = 1'b1;
        send_both(32'h1000_00FF, 32'h2000_00FF);
        flag_clr = 1'b0;
        n_cmp++; if (ovf !== 1'b1) begin $display("FAIL prio_ovf got %b want 1", ovf); n_bad++; end
`ifdef I2S_FRAME_FIFO_OVF_CNT_EN
        n_cmp++; if (ovf_cnt !== 8'd1) begin $display("FAIL prio_cnt got %0d want 1", ovf_cnt); n_bad++; end
        left_data = 32'h1; right_data = 32'h2; left_vld = 1'b1; right_vld = 1'b1;
        repeat (300) tick();
        left_vld = 1'b0; right_vld = 1'b0;
        n_cmp++; if (ovf_cnt !== 8'd255) begin $display("FAIL cnt_sat got %0d want 255", ovf_cnt); n_bad++; end
        clear_flags();
        n_cmp++; if (ovf_cnt !== 8'd0) begin $display("FAIL cnt_clr got %0d want 0", ovf_cnt); n_bad++; end
`endif
        clear_flags();
        n_cmp++; if (ovf !== 1'b0) begin $display("FAIL prio_ovf_clr got %b want 0", ovf); n_bad++; end
        flag_clr = 1'b1;
        send_right(32'h0000_0044);
        flag_clr = 1'b0;
        n_cmp++; if (desync !== 1'b1) begin $display("FAIL prio_desync got %b want 1", desync); n_bad++; end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) send_both(32'h5000_0000 + i, 32'h6000_0000 + i);
        send_left(32'h5000_00AA);
        n_cmp++; if (count !== 5'd3 || desync !== 1'b0) begin
            $display("FAIL rmid_pre got count=%0d desync=%b want 3/0", count, desync); n_bad++; end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (count !== 5'd0 || frame_vld !== 1'b0 || frame_left !== 32'h0) begin
            $display("FAIL rmid_async got count=%0d vld=%b left=%h want 0/0/0", count, frame_vld, frame_left); n_bad++; end
        tick();
        rst = 1'b0;
        tick();
        send_right(32'h6000_00BB);
        n_cmp++; if (desync !== 1'b1 || count !== 5'd0 || frame_vld !== 1'b0) begin
            $display("FAIL rmid_orphan got desync=%b count=%0d vld=%b want 1/0/0", desync, count, frame_vld); n_bad++; end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_full_pop();
        test_desync();
        test_back_to_back();
        test_flag_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_frame_fifo.md
Name: i2s_frame_fifo

Overview:
- Downstream consumer of the I2S receive controller's per-channel outputs (left/right data plus single-cycle valid strobes).
- Pairs each left sample with the following right sample into one stereo frame.
- Buffers frames in a synchronous FWFT FIFO with a valid/ready read interface for the host/processor.
- Runs entirely in the serial-clock (SCK) domain; no CDC inside this block.

Parameters:
- DATA_WIDTH, 32: bits per channel sample.
- DEPTH_LOG2, 4: FIFO depth = 2**DEPTH_LOG2 frames.
- OVF_CNT_WIDTH, 8: width of the dropped-frame counter (optional feature only).

Ports:
- clk  input  1  SCK; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- i_left_data  input  DATA_WIDTH  left sample from receiver.
- i_left_vld  input  1  one-cycle strobe; i_left_data valid this cycle.
- i_right_data  input  DATA_WIDTH  right sample from receiver.
- i_right_vld  input  1  one-cycle strobe; i_right_data valid this cycle.
- o_frame_left  output  DATA_WIDTH  head-of-FIFO left sample.
- o_frame_right  output  DATA_WIDTH  head-of-FIFO right sample.
- o_frame_vld  output  1  FIFO not empty; head frame presented.
- i_frame_rdy  input  1  consumer accepts head frame when o_frame_vld=1.
- o_count  output  DEPTH_LOG2+1  frames stored, 0..2**DEPTH_LOG2.
- o_full  output  1  o_count == 2**DEPTH_LOG2.
- o_ovf  output  1  sticky: a completed frame was dropped because the FIFO was full.
- o_desync  output  1  sticky: orphan right sample or overwritten unpaired left sample.
- i_flag_clr  input  1  clears o_ovf and o_desync.

Behaviour:
- Reset (async assert, sync-safe release):
  - Pair FSM goes to WAIT_L.
  - Pointers and count go to 0.
  - o_frame_vld=0, o_full=0, o_ovf=0, o_desync=0.
  - o_frame_left/right=0 while empty.
  - Reset mid-operation discards stored frames and any pending left sample.
- Pair FSM, two states:
  - WAIT_L + i_left_vld only: latch left, go HAVE_L.
  - WAIT_L + i_right_vld only: drop the sample, set o_desync, stay WAIT_L.
  - WAIT_L + both strobes same cycle: form frame {i_left_data, i_right_data} directly, stay WAIT_L.
  - HAVE_L + i_right_vld only: form frame {latched left, i_right_data}, go WAIT_L.
  - HAVE_L + i_left_vld only: overwrite latched left, set o_desync, stay HAVE_L.
  - HAVE_L + both strobes: form frame {latched left, i_right_data}, latch new left, stay HAVE_L.
- Write: a formed frame is written on the same posedge it is formed.
  - Latency: o_frame_vld rises in the cycle after the completing i_right_vld (empty FIFO).
- Read: FWFT.
  - Head data is valid whenever o_frame_vld=1.
  - Pop occurs when o_frame_vld & i_frame_rdy at posedge.
  - Head data must hold stable while vld=1 and rdy=0.
- Full:
  - Write with no pop in the same cycle: frame dropped, o_ovf set, count unchanged.
  - Write with a simultaneous pop: write accepted, count unchanged.
- Empty: i_frame_rdy ignored, no pointer movement.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged.
- Pointers: DEPTH_LOG2 bits, natural wrap at 2**DEPTH_LOG2-1 -> 0.
- Flags: i_flag_clr clears both sticky flags; a set event in the same cycle wins (flag reads 1 afterwards).

Optional Feature:
- Macro: I2S_FRAME_FIFO_OVF_CNT_EN.
- Defined:
  - Adds output o_ovf_cnt [OVF_CNT_WIDTH-1:0], reset 0.
  - Increments on every dropped frame and saturates at all-ones.
  - Cleared by i_flag_clr; a drop in the same cycle as clear gives 1.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then left=0x11111111 strobe, right=0x22222222 strobe 32 cycles later -> one cycle after the right strobe: o_frame_vld=1, left=0x11111111, right=0x22222222, o_count=1.
- Push 16 frames with rdy=0, then push a 17th -> o_full=1, o_ovf=1, o_count=16, frame 17 lost; drain with rdy=1 -> frames 1..16 in order, o_frame_vld=0 after the 16th pop.
- Full FIFO, completing right strobe in the same cycle as pop -> o_ovf stays 0, o_count stays 16, new frame appears last on drain.
- Right strobe in WAIT_L, then left A, left B, right C -> o_desync=1, single frame {B,C} stored.
- Assert rst while in HAVE_L with 3 frames stored -> o_count=0, o_frame_vld=0; next right strobe is treated as an orphan (o_desync=1).
- With I2S_FRAME_FIFO_OVF_CNT_EN, force 300 drops at OVF_CNT_WIDTH=8 -> o_ovf_cnt=255; i_flag_clr -> 0.
